// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a uart_receiver datapath.
//   - Generates baud_rate_signal (square wave, half-period = max(div,2) clk).
//   - Edge-detects rx_valid and captures one byte per rising edge into a
//     first-word-fall-through FIFO drained over m_valid/m_ready.
//   - Reports a sticky overrun flag and a one-shot idle_timeout pulse.
// Ports:
//   clk, rst (async active-low)      clock / reset
//   enable                           run baud generator and capture
//   div[DIV_W]                       baud half-period in clk cycles
//   baud_rate_signal                 baud clock out to the receiver
//   rx_data[8], rx_valid             receiver byte and valid_data
//   m_data[8], m_valid, m_ready      FIFO head and handshake
//   fifo_count                       FIFO occupancy 0..FIFO_DEPTH
//   overrun, clr_overrun             sticky drop flag and its clear
//   idle_timeout                     one-cycle line-idle pulse
module uart_rx_ctrl #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_BAUDS = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [DIV_W-1:0]                div,
  output logic                            baud_rate_signal,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [7:0]                      m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overrun,
  input  logic                            clr_overrun,
  output logic                            idle_timeout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_BAUDS + 1);

  // ---------------- baud generator ----------------
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] half_lat;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] half;
  logic             wrap;
  logic             baud_rise;

  assign eff_div = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  // half_lat==0 only between reset release and the first wrap; use live div then.
  assign half      = (half_lat == '0) ? eff_div : half_lat;
  assign wrap      = enable && (baud_cnt == half - DIV_W'(1));
  assign baud_rise = wrap && !baud_rate_signal;

  // Half-period length is latched at each wrap so mid-count div changes wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt         <= '0;
      half_lat         <= '0;
      baud_rate_signal <= 1'b0;
    end else if (!enable) begin
      baud_cnt         <= '0;
      half_lat         <= eff_div;
      baud_rate_signal <= 1'b0;
    end else if (wrap) begin
      baud_cnt         <= '0;
      half_lat         <= eff_div;
      baud_rate_signal <= ~baud_rate_signal;
    end else begin
      baud_cnt         <= baud_cnt + DIV_W'(1);
    end
  end

  // ---------------- capture ----------------
  logic rx_valid_d;
  logic push;

  assign push = enable && rx_valid && !rx_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_valid_d <= 1'b0;
    else      rx_valid_d <= rx_valid;
  end

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [CNT_W-1:0] count_next;
  logic [7:0]       head_next;

  assign rd_next = rd_ptr + PTR_W'(1);
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop     = m_valid && m_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Occupancy and next registered head byte (first-word-fall-through).
  always_comb begin
    count_next = fifo_count;
    head_next  = m_data;
    if (push_ok && !pop)      count_next = fifo_count + CNT_W'(1);
    else if (pop && !push_ok) count_next = fifo_count - CNT_W'(1);
    if (pop) begin
      // Head comes from storage if another entry remains, else from the bypass.
      if (fifo_count > CNT_W'(1)) head_next = mem[rd_next];
      else if (push_ok)           head_next = rx_data;
    end else if (fifo_count == '0 && push_ok) begin
      head_next = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_next;
      fifo_count <= count_next;
      m_valid    <= (count_next != '0);
      m_data     <= head_next;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // ---------------- idle timeout ----------------
  logic [TO_W-1:0] to_cnt;

  // Saturating count of baud rising edges since the last push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt       <= '0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= baud_rise && !push && (fifo_count != '0) &&
                      (to_cnt == TO_W'(TIMEOUT_BAUDS - 1));
      if (push)
        to_cnt <= '0;
      else if (baud_rise && to_cnt != TO_W'(TIMEOUT_BAUDS))
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] div;
  logic        baud_rate_signal;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        clr_overrun;
  logic        idle_timeout;

  uart_rx_ctrl #(.DIV_W(16), .FIFO_DEPTH(4), .TIMEOUT_BAUDS(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div(div),
    .baud_rate_signal(baud_rate_signal), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overrun(overrun), .clr_overrun(clr_overrun),
    .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
  endfunction

  // Scoreboard monitor: every accepted pop is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("pop_with_empty_scoreboard", exp_q.size(), 1);
      else chk("pop_data", int'(m_data), int'(exp_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    rx_data  = b;
    rx_valid = 1'b1;
    if (accepted) exp_q.push_back(b);
    tick;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick;
  endtask

  task automatic measure_half(output int n);
    logic p;
    p = baud_rate_signal;
    n = 0;
    do begin
      tick;
      n++;
    end while (baud_rate_signal == p && n < 100);
    if (n >= 100) chk("baud_toggle_timeout", n, 0);
  endtask

  task automatic wait_rises(input int n);
    int r;
    int c;
    logic p;
    r = 0;
    c = 0;
    p = baud_rate_signal;
    while (r < n && c < 5000) begin
      tick;
      c++;
      if (baud_rate_signal && !p) r++;
      p = baud_rate_signal;
    end
    if (r < n) chk("baud_rise_timeout", r, n);
  endtask

  // Receiver stand-in: a frame spans 10 baud periods, then valid_data is held as a level.
  task automatic send_frame(input logic [7:0] b);
    wait_rises(10);
    rx_data  = b;
    rx_valid = 1'b1;
    exp_q.push_back(b);
    tick;
    chk("frame_m_valid", int'(m_valid), 1);
    chk("frame_m_data", int'(m_data), int'(b));
    tick;
    tick;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick;
  endtask

  task automatic drain;
    int c;
    c = 0;
    m_ready = 1'b1;
    while (fifo_count != 0 && c < 50) begin
      tick;
      c++;
    end
    m_ready = 1'b0;
    chk("drain_count", int'(fifo_count), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_baud"}, int'(baud_rate_signal), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_count"}, int'(fifo_count), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_idle"}, int'(idle_timeout), 0);
  endtask

  task automatic watch_timeout(input int rises_max, output int pulses, output int at);
    int r;
    int c;
    logic p;
    r = 0;
    c = 0;
    pulses = 0;
    at = -1;
    p = baud_rate_signal;
    while (r < rises_max && c < 3000) begin
      tick;
      c++;
      if (baud_rate_signal && !p) r++;
      p = baud_rate_signal;
      if (idle_timeout) begin
        pulses++;
        at = r;
      end
    end
    if (r < rises_max) chk("timeout_watch_bound", r, rises_max);
  endtask

  initial begin
    int n;
    int pulses;
    int at;
    rst = 1'b0; enable = 1'b0; div = 16'd5; rx_valid = 1'b0; rx_data = 8'h00;
    m_ready = 1'b0; clr_overrun = 1'b0;
    tick; tick; tick;
    check_reset_outputs("reset");

    // Baud generator
    rst = 1'b1;
    enable = 1'b1;
    measure_half(n); chk("baud_first_half_div5", n, 5);
    measure_half(n); chk("baud_half_div5", n, 5);
    div = 16'd0;
    measure_half(n); chk("baud_div_change_deferred", n, 5);
    measure_half(n); chk("baud_half_div0", n, 2);
    div = 16'd1;
    measure_half(n);
    measure_half(n); chk("baud_half_div1", n, 2);
    div = 16'd5;
    measure_half(n);
    measure_half(n); chk("baud_half_div5_again", n, 5);

    // Single frame with consumer ready
    m_ready = 1'b1;
    send_frame(8'h4B);
    chk("frame_count_after_pop", int'(fifo_count), 0);
    m_ready = 1'b0;

    // Overrun
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b0);
    chk("full_count", int'(fifo_count), 4);
    chk("overrun_set", int'(overrun), 1);
    chk("head_held", int'(m_data), 8'h11);
    drain;
    chk("overrun_sticky", int'(overrun), 1);
    clr_overrun = 1'b1; tick; clr_overrun = 1'b0;
    chk("overrun_cleared", int'(overrun), 0);

    // Drop and clear in the same cycle: set wins
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hA3, 1'b1);
    push_byte(8'hA4, 1'b1);
    rx_data = 8'hA5; rx_valid = 1'b1; clr_overrun = 1'b1;
    tick;
    rx_valid = 1'b0; clr_overrun = 1'b0;
    tick;
    chk("overrun_set_wins", int'(overrun), 1);
    clr_overrun = 1'b1; tick; clr_overrun = 1'b0;
    chk("overrun_cleared2", int'(overrun), 0);

    // Full FIFO: push and pop together
    rx_data = 8'h66; rx_valid = 1'b1; m_ready = 1'b1;
    exp_q.push_back(8'h66);
    tick;
    rx_valid = 1'b0; m_ready = 1'b0;
    tick;
    chk("full_push_pop_count", int'(fifo_count), 4);
    chk("full_push_pop_no_overrun", int'(overrun), 0);
    chk("full_push_pop_head", int'(m_data), 8'hA2);
    drain;
    chk("scoreboard_empty_after_drain", exp_q.size(), 0);

    // Idle timeout with one byte held
    rx_data = 8'h77; rx_valid = 1'b1; exp_q.push_back(8'h77);
    tick;
    rx_valid = 1'b0;
    watch_timeout(45, pulses, at);
    chk("timeout_pulse_count", pulses, 1);
    chk("timeout_pulse_rise", at, 20);
    drain;

    // Idle timeout with the FIFO empty at threshold
    m_ready = 1'b1;
    rx_data = 8'h78; rx_valid = 1'b1; exp_q.push_back(8'h78);
    tick;
    rx_valid = 1'b0;
    watch_timeout(30, pulses, at);
    chk("timeout_empty_no_pulse", pulses, 0);
    m_ready = 1'b0;

    // Reset mid-frame with two bytes held
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    chk("pre_reset_count", int'(fifo_count), 2);
    wait_rises(4);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    tick; tick;
    rst = 1'b1;
    m_ready = 1'b1;
    send_frame(8'hA5);
    tick; tick;
    chk("post_reset_count", int'(fifo_count), 0);
    chk("post_reset_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the uart_receiver datapath. It generates the receiver's baud_rate_signal from a programmable divisor and edge-detects the receiver's valid_data. Each received byte goes into a small FIFO, which a downstream consumer drains over a valid/ready handshake. The block also reports FIFO overrun and a line-idle timeout.

Parameters:
DIV_W, 16, width of the baud divisor input
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2
TIMEOUT_BAUDS, 20, baud ticks with no new byte before idle_timeout fires

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset: rst=0 resets all state immediately; release is synchronous to clk
enable  input  1  1 = baud generator and capture running
div  input  DIV_W  half-period of baud_rate_signal, in clk cycles
baud_rate_signal  output  1  square-wave baud clock to uart_receiver
rx_data  input  8  uart_receiver data
rx_valid  input  1  uart_receiver valid_data
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
overrun  output  1  sticky; a byte was dropped
clr_overrun  input  1  synchronous clear of overrun
idle_timeout  output  1  one-cycle pulse

Behaviour:
- Reset (rst=0) values: baud_rate_signal=0, m_valid=0, m_data=0, fifo_count=0, overrun=0, idle_timeout=0. Internal state also resets: counters, FIFO pointers, the rx_valid edge register and the timeout counter.
- Baud generator:
  - Counter runs 0..eff_div-1, where eff_div = max(div,2).
  - When the counter is at eff_div-1, it wraps to 0 and baud_rate_signal toggles. Period is 2*eff_div clk cycles.
  - div is sampled only at wrap; a mid-count change takes effect on the next half-period.
  - enable=0: counter=0 and baud_rate_signal=0 on the next clk; FIFO contents and flags retained.
  - enable 0->1: first toggle (to 1) occurs eff_div cycles later.
- Capture:
  - push = enable & rx_valid & ~rx_valid_d, where rx_valid_d is rx_valid registered one cycle. This gives exactly one push per byte whether valid_data is a pulse or a level.
  - rx_data is sampled in the push cycle.
- FIFO:
  - Synchronous, first-word-fall-through. Pop = m_valid & m_ready.
  - Push in cycle t -> m_valid=1 and the byte on m_data at t+1 (when the FIFO was empty).
  - m_data holds stable while m_valid=1 and m_ready=0.
  - Pop when empty: no effect.
  - Push when full and no pop: byte dropped, overrun<=1, count unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- Overrun:
  - Set on a dropped byte; cleared by clr_overrun.
  - clr_overrun and a drop in the same cycle: overrun=1 (set wins).
- Idle timeout:
  - Counter clears on push and advances on each rising edge of baud_rate_signal.
  - When it reaches TIMEOUT_BAUDS while fifo_count>0, idle_timeout pulses high for one clk. The counter then saturates, so there is no repeat until the next push.
  - fifo_count=0 at threshold: no pulse.
  - enable=0: counter frozen.
- Reset asserted mid-frame or with a non-empty FIFO: all state clears immediately and FIFO contents are lost. After release, operation restarts as after power-up.

Test Plan:
- Reset release, enable=1, div=5 -> baud_rate_signal toggles every 5 clk (period 10); div=0 or div=1 -> period 4.
- Drive uart_receiver with serial frame 0x4B from baud_rate_signal, m_ready=1 -> m_data=0x4B with m_valid=1 one clk after rx_valid rises; fifo_count returns to 0 after the pop.
- m_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> fifo_count=4, overrun=1, then m_ready=1 drains 0x11,0x22,0x33,0x44 in order; clr_overrun -> overrun=0.
- FIFO full, push 0x66 and pop in the same cycle -> fifo_count stays 4, overrun stays 0, 0x66 is the last byte out.
- One byte held (m_ready=0), TIMEOUT_BAUDS=20 -> single idle_timeout pulse on the 20th baud rising edge after the push, none thereafter; repeat with an empty FIFO -> no pulse.
- rst=0 asserted mid-frame with fifo_count=2 -> all outputs go to reset values immediately; after release, frame 0xA5 is received correctly.
